// File: rtl/acl2_mode_sequencer_if.sv
// acl2_mode_sequencer_if
// Groups the request, handshake and status signals that pass between the
// UI/driver side and the ACL2 mode sequencer.
//   slave  : the sequencer view (samples i_*, drives o_*)
//   master : the environment view (drives i_*, samples o_*)
// Signals:
//   i_start                 run request level
//   i_mode_linked           1 = linked mode, 0 = measurement mode
//   i_command_ready         driver command-ready handshake
//   i_data_valid            driver data-valid pulse
//   i_enum_active[3:0]      active preset enum
//   i_enum_inactive[3:0]    inactive preset enum
//   o_cmd_*                 one-cycle command pulses to the driver
//   o_running               sequencer is in run
//   o_fault                 sequencer is in fault
//   o_fault_code[1:0]       0 none, 1 ack timeout, 2 done timeout, 3 watchdog
//   o_sample_count[15:0]    data-valid pulses counted in run
interface acl2_mode_sequencer_if;
    logic        i_start;
    logic        i_mode_linked;
    logic        i_command_ready;
    logic        i_data_valid;
    logic [3:0]  i_enum_active;
    logic [3:0]  i_enum_inactive;
    logic        o_cmd_soft_reset_acl2;
    logic        o_cmd_init_linked_mode;
    logic        o_cmd_start_linked_mode;
    logic        o_cmd_init_measur_mode;
    logic        o_cmd_start_measur_mode;
    logic        o_running;
    logic        o_fault;
    logic [1:0]  o_fault_code;
    logic [15:0] o_sample_count;

    modport slave (
        input  i_start, i_mode_linked, i_command_ready, i_data_valid,
               i_enum_active, i_enum_inactive,
        output o_cmd_soft_reset_acl2, o_cmd_init_linked_mode,
               o_cmd_start_linked_mode, o_cmd_init_measur_mode,
               o_cmd_start_measur_mode, o_running, o_fault, o_fault_code,
               o_sample_count
    );

    modport master (
        output i_start, i_mode_linked, i_command_ready, i_data_valid,
               i_enum_active, i_enum_inactive,
        input  o_cmd_soft_reset_acl2, o_cmd_init_linked_mode,
               o_cmd_start_linked_mode, o_cmd_init_measur_mode,
               o_cmd_start_measur_mode, o_running, o_fault, o_fault_code,
               o_sample_count
    );
endinterface

// File: rtl/acl2_mode_sequencer.sv
// acl2_mode_sequencer
// Supervisory controller for the ACL2 custom driver. Issues soft reset, init
// and start command pulses through the driver's command-ready handshake,
// re-initialises on preset changes, counts measurement samples and watches
// the data-valid stream with a watchdog.
// Ports:
//   i_clk_20mhz    20 MHz clock
//   i_rstn_20mhz   asynchronous active-low reset
//   bus            acl2_mode_sequencer_if.slave (requests, handshake, status)
// Optional feature macro: ACL2_SEQ_AUTO_RECOVER_EN
//   defined     : fault waits the reset delay, then restarts (i_start = 1)
//                 or returns to idle (i_start = 0)
//   not defined : fault is left only when i_start = 0 is seen
module acl2_mode_sequencer #(
    parameter int unsigned parm_fast_simulation = 0,
    parameter int unsigned parm_ack_timeout     = 2000,
    parameter int unsigned parm_done_timeout    = 2000000,
    parameter int unsigned parm_reset_delay     = 200000,
    parameter int unsigned parm_watchdog        = 4000000
) (
    input  logic                        i_clk_20mhz,
    input  logic                        i_rstn_20mhz,
    acl2_mode_sequencer_if.slave        bus
);

    // Fast simulation shrinks every limit by 1000 but never below one cycle.
    function automatic logic [31:0] scaleLimit(input logic [31:0] v);
        logic [31:0] s;
        s = (parm_fast_simulation != 0) ? (v / 32'd1000) : v;
        if (s == 32'd0) s = 32'd1;
        return s;
    endfunction

    localparam logic [31:0] ACK_LIM  = scaleLimit(parm_ack_timeout);
    localparam logic [31:0] DONE_LIM = scaleLimit(parm_done_timeout);
    localparam logic [31:0] RST_LIM  = scaleLimit(parm_reset_delay);
    localparam logic [31:0] WD_LIM   = scaleLimit(parm_watchdog);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SOFT_RESET, ST_RST_DELAY, ST_INIT, ST_START, ST_RUN, ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE, PH_WAIT_LOW, PH_WAIT_HIGH
    } phase_t;

    state_t      state_q;
    phase_t      phase_q;
    logic [31:0] timer_q;
    logic        stopping_q;
    logic        modeLinked_q;
    logic [3:0]  enumActive_q;
    logic [3:0]  enumInactive_q;
    logic        softReset_q;
    logic        initLinked_q;
    logic        startLinked_q;
    logic        initMeasur_q;
    logic        startMeasur_q;
    logic        running_q;
    logic        fault_q;
    logic [1:0]  faultCode_q;
    logic [15:0] sampleCount_q;

    // One timer serves every state: handshake phases, reset delay, run
    // watchdog and fault recovery. It is cleared on every state/phase entry.
    // stopping_q marks a soft reset entered from a stop request, which ends
    // in idle instead of continuing to the reset delay.
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_ISSUE;
            timer_q        <= '0;
            stopping_q     <= 1'b0;
            modeLinked_q   <= 1'b0;
            enumActive_q   <= '0;
            enumInactive_q <= '0;
            softReset_q    <= 1'b0;
            initLinked_q   <= 1'b0;
            startLinked_q  <= 1'b0;
            initMeasur_q   <= 1'b0;
            startMeasur_q  <= 1'b0;
            running_q      <= 1'b0;
            fault_q        <= 1'b0;
            faultCode_q    <= 2'd0;
            sampleCount_q  <= '0;
        end else begin
            softReset_q   <= 1'b0;
            initLinked_q  <= 1'b0;
            startLinked_q <= 1'b0;
            initMeasur_q  <= 1'b0;
            startMeasur_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_q    <= ST_SOFT_RESET;
                        phase_q    <= PH_ISSUE;
                        stopping_q <= 1'b0;
                    end
                end

                ST_SOFT_RESET, ST_INIT, ST_START: begin
                    case (phase_q)
                        PH_ISSUE: begin
                            if (bus.i_command_ready) begin
                                case (state_q)
                                    ST_SOFT_RESET: softReset_q <= 1'b1;
                                    ST_INIT: begin
                                        initLinked_q <= modeLinked_q;
                                        initMeasur_q <= !modeLinked_q;
                                    end
                                    default: begin
                                        startLinked_q <= modeLinked_q;
                                        startMeasur_q <= !modeLinked_q;
                                    end
                                endcase
                                phase_q <= PH_WAIT_LOW;
                                timer_q <= '0;
                            end
                        end
                        PH_WAIT_LOW: begin
                            if (!bus.i_command_ready) begin
                                phase_q <= PH_WAIT_HIGH;
                                timer_q <= '0;
                            end else if (timer_q >= ACK_LIM - 32'd1) begin
                                state_q     <= ST_FAULT;
                                phase_q     <= PH_ISSUE;
                                timer_q     <= '0;
                                fault_q     <= 1'b1;
                                faultCode_q <= 2'd1;
                            end else begin
                                timer_q <= timer_q + 32'd1;
                            end
                        end
                        PH_WAIT_HIGH: begin
                            if (bus.i_command_ready) begin
                                phase_q <= PH_ISSUE;
                                timer_q <= '0;
                                case (state_q)
                                    ST_SOFT_RESET: begin
                                        state_q    <= stopping_q ? ST_IDLE : ST_RST_DELAY;
                                        stopping_q <= 1'b0;
                                    end
                                    ST_INIT: state_q <= ST_START;
                                    default: begin
                                        state_q       <= ST_RUN;
                                        running_q     <= 1'b1;
                                        sampleCount_q <= '0;
                                    end
                                endcase
                            end else if (timer_q >= DONE_LIM - 32'd1) begin
                                state_q     <= ST_FAULT;
                                phase_q     <= PH_ISSUE;
                                timer_q     <= '0;
                                fault_q     <= 1'b1;
                                faultCode_q <= 2'd2;
                            end else begin
                                timer_q <= timer_q + 32'd1;
                            end
                        end
                        default: phase_q <= PH_ISSUE;
                    endcase
                end

                ST_RST_DELAY: begin
                    if (timer_q >= RST_LIM - 32'd1) begin
                        state_q        <= ST_INIT;
                        phase_q        <= PH_ISSUE;
                        timer_q        <= '0;
                        modeLinked_q   <= bus.i_mode_linked;
                        enumActive_q   <= bus.i_enum_active;
                        enumInactive_q <= bus.i_enum_inactive;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end

                // Exits in priority order: watchdog, stop, preset change.
                // A data-valid in an exit cycle is still counted.
                ST_RUN: begin
                    if (bus.i_data_valid) begin
                        sampleCount_q <= sampleCount_q + 16'd1;
                    end
                    if (timer_q >= WD_LIM - 32'd1) begin
                        state_q     <= ST_FAULT;
                        timer_q     <= '0;
                        running_q   <= 1'b0;
                        fault_q     <= 1'b1;
                        faultCode_q <= 2'd3;
                    end else if (!bus.i_start) begin
                        state_q    <= ST_SOFT_RESET;
                        phase_q    <= PH_ISSUE;
                        timer_q    <= '0;
                        running_q  <= 1'b0;
                        stopping_q <= 1'b1;
                    end else if ((bus.i_enum_active != enumActive_q) ||
                                 (bus.i_enum_inactive != enumInactive_q)) begin
                        state_q        <= ST_INIT;
                        phase_q        <= PH_ISSUE;
                        timer_q        <= '0;
                        running_q      <= 1'b0;
                        modeLinked_q   <= bus.i_mode_linked;
                        enumActive_q   <= bus.i_enum_active;
                        enumInactive_q <= bus.i_enum_inactive;
                    end else begin
                        timer_q <= bus.i_data_valid ? 32'd0 : (timer_q + 32'd1);
                    end
                end

                ST_FAULT: begin
`ifdef ACL2_SEQ_AUTO_RECOVER_EN
                    if (timer_q >= RST_LIM - 32'd1) begin
                        state_q     <= bus.i_start ? ST_SOFT_RESET : ST_IDLE;
                        phase_q     <= PH_ISSUE;
                        timer_q     <= '0;
                        stopping_q  <= 1'b0;
                        fault_q     <= 1'b0;
                        faultCode_q <= 2'd0;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
`else
                    if (!bus.i_start) begin
                        state_q     <= ST_IDLE;
                        phase_q     <= PH_ISSUE;
                        timer_q     <= '0;
                        fault_q     <= 1'b0;
                        faultCode_q <= 2'd0;
                    end
`endif
                end

                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= PH_ISSUE;
                end
            endcase
        end
    end

    assign bus.o_cmd_soft_reset_acl2   = softReset_q;
    assign bus.o_cmd_init_linked_mode  = initLinked_q;
    assign bus.o_cmd_start_linked_mode = startLinked_q;
    assign bus.o_cmd_init_measur_mode  = initMeasur_q;
    assign bus.o_cmd_start_measur_mode = startMeasur_q;
    assign bus.o_running               = running_q;
    assign bus.o_fault                 = fault_q;
    assign bus.o_fault_code            = faultCode_q;
    assign bus.o_sample_count          = sampleCount_q;

endmodule

// File: tb/tb_acl2_mode_sequencer.sv
// tb_acl2_mode_sequencer
// Directed bench for acl2_mode_sequencer in fast-simulation mode
// (ack 20, done 2000, reset delay 200, watchdog 4000 cycles).
// A driver model drops command-ready 2 cycles after each pulse and restores
// it 100 cycles later; a monitor logs pulses as codes
// 1 soft_reset, 2 init_linked, 3 start_linked, 4 init_measur, 5 start_measur.
// Honours ACL2_SEQ_AUTO_RECOVER_EN for the fault-exit checks.
module tb_acl2_mode_sequencer;

    logic clk;
    logic rstN;
    int   assertCount = 0;
    int   failCount   = 0;
    int   pulseLog[$];
    int   multiPulse  = 0;
    bit   skipInit    = 1'b0;

    acl2_mode_sequencer_if bus();

    acl2_mode_sequencer #(
        .parm_fast_simulation (1),
        .parm_ack_timeout     (20000),
        .parm_done_timeout    (2000000),
        .parm_reset_delay     (200000),
        .parm_watchdog        (4000000)
    ) dut (
        .i_clk_20mhz  (clk),
        .i_rstn_20mhz (rstN),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor
    always @(negedge clk) begin
        if ($countones({bus.o_cmd_soft_reset_acl2, bus.o_cmd_init_linked_mode,
                        bus.o_cmd_start_linked_mode, bus.o_cmd_init_measur_mode,
                        bus.o_cmd_start_measur_mode}) > 1)
            multiPulse = multiPulse + 1;
        if (bus.o_cmd_soft_reset_acl2)   pulseLog.push_back(1);
        if (bus.o_cmd_init_linked_mode)  pulseLog.push_back(2);
        if (bus.o_cmd_start_linked_mode) pulseLog.push_back(3);
        if (bus.o_cmd_init_measur_mode)  pulseLog.push_back(4);
        if (bus.o_cmd_start_measur_mode) pulseLog.push_back(5);
    end

    // Driver command-ready model
    initial begin
        bus.i_command_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if ((bus.o_cmd_soft_reset_acl2 || bus.o_cmd_init_linked_mode ||
                 bus.o_cmd_start_linked_mode || bus.o_cmd_init_measur_mode ||
                 bus.o_cmd_start_measur_mode) &&
                !(skipInit && (bus.o_cmd_init_linked_mode || bus.o_cmd_init_measur_mode))) begin
                repeat (2) @(posedge clk);
                #1 bus.i_command_ready = 1'b0;
                repeat (100) @(posedge clk);
                #1 bus.i_command_ready = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitRunning(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.o_running) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic waitFault(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.o_fault) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic waitLogSize(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (pulseLog.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.i_start = 1'b0;
        bus.i_mode_linked = 1'b1;
        bus.i_data_valid = 1'b0;
        bus.i_enum_active = 4'd0;
        bus.i_enum_inactive = 4'd0;
        #3;
        assertCount++;
        if ({bus.o_running, bus.o_fault, bus.o_fault_code} !== 4'b0) begin
            failCount++;
            $display("[TB] FAIL reset_status: got %b, expected 0000", {bus.o_running, bus.o_fault, bus.o_fault_code});
        end
        assertCount++;
        if (bus.o_sample_count !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_count: got %0d, expected 0", bus.o_sample_count);
        end
        tick(3);
        rstN = 1'b1;
        tick(20);
        assertCount++;
        if (pulseLog.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL idle_no_pulse: got %0d pulses, expected 0", pulseLog.size());
        end
    endtask

    task automatic test_power_up_linked();
        int expSeq[3] = '{1, 2, 3};
        bit ok;
        pulseLog.delete();
        bus.i_start = 1'b1;
        bus.i_mode_linked = 1'b1;
        waitRunning(3000, ok);
        assertCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL powerup_running: got timeout, expected o_running=1");
        end
        assertCount++;
        if (pulseLog.size() !== 3) begin
            failCount++;
            $display("[TB] FAIL powerup_pulse_count: got %0d, expected 3", pulseLog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                assertCount++;
                if (pulseLog[i] !== expSeq[i]) begin
                    failCount++;
                    $display("[TB] FAIL powerup_seq[%0d]: got %0d, expected %0d", i, pulseLog[i], expSeq[i]);
                end
            end
        end
        assertCount++;
        if (bus.o_sample_count !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL powerup_count: got %0d, expected 0", bus.o_sample_count);
        end
    endtask

    task automatic test_run_counting();
        repeat (5) begin
            bus.i_data_valid = 1'b1;
            tick(1);
            bus.i_data_valid = 1'b0;
            tick(1);
        end
        assertCount++;
        if (bus.o_sample_count !== 16'd5) begin
            failCount++;
            $display("[TB] FAIL count_5: got %0d, expected 5", bus.o_sample_count);
        end
        bus.i_data_valid = 1'b1;
        tick(65536);
        bus.i_data_valid = 1'b0;
        assertCount++;
        if (bus.o_sample_count !== 16'd5) begin
            failCount++;
            $display("[TB] FAIL count_wrap: got %0d, expected 5", bus.o_sample_count);
        end
        assertCount++;
        if (bus.o_running !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL count_still_running: got %b, expected 1", bus.o_running);
        end
    endtask

    task automatic test_preset_change();
        int expSeq[2] = '{4, 5};
        bit ok;
        pulseLog.delete();
        bus.i_mode_linked = 1'b0;
        tick(10);
        assertCount++;
        if (pulseLog.size() !== 0 || bus.o_running !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mode_change_in_run: got %0d pulses running=%b, expected 0 pulses running=1",
                     pulseLog.size(), bus.o_running);
        end
        bus.i_enum_active = 4'd1;
        tick(1);
        waitLogSize(2, 1000, ok);
        if (ok) waitRunning(1000, ok);
        assertCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL preset_reinit: got timeout, expected re-init and run");
        end
        assertCount++;
        if (pulseLog.size() !== 2) begin
            failCount++;
            $display("[TB] FAIL preset_pulse_count: got %0d, expected 2", pulseLog.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                assertCount++;
                if (pulseLog[i] !== expSeq[i]) begin
                    failCount++;
                    $display("[TB] FAIL preset_seq[%0d]: got %0d, expected %0d", i, pulseLog[i], expSeq[i]);
                end
            end
        end
        assertCount++;
        if (bus.o_sample_count !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL preset_count_clear: got %0d, expected 0", bus.o_sample_count);
        end
        repeat (3) begin
            bus.i_data_valid = 1'b1;
            tick(1);
            bus.i_data_valid = 1'b0;
            tick(1);
        end
        assertCount++;
        if (bus.o_sample_count !== 16'd3) begin
            failCount++;
            $display("[TB] FAIL preset_count_3: got %0d, expected 3", bus.o_sample_count);
        end
    endtask

    task automatic test_async_reset();
        int expSeq[3] = '{1, 2, 3};
        bit ok;
        pulseLog.delete();
        bus.i_start = 1'b0;
        waitLogSize(1, 100, ok);
        for (int i = 0; i < 20 && bus.i_command_ready; i++) tick(1);
        tick(10);
        assertCount++;
        if (!ok || bus.i_command_ready !== 1'b0 || bus.o_sample_count !== 16'd3 || bus.o_running !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stop_handshake_hold: got pulse=%b ready=%b count=%0d running=%b, expected 1 0 3 0",
                     ok, bus.i_command_ready, bus.o_sample_count, bus.o_running);
        end
        @(negedge clk); #2;
        rstN = 1'b0;
        #1;
        assertCount++;
        if (bus.o_sample_count !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL async_reset_count: got %0d, expected 0", bus.o_sample_count);
        end
        assertCount++;
        if ({bus.o_running, bus.o_fault, bus.o_fault_code, bus.o_cmd_soft_reset_acl2} !== 5'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset_outputs: got %b, expected 00000",
                     {bus.o_running, bus.o_fault, bus.o_fault_code, bus.o_cmd_soft_reset_acl2});
        end
        tick(3);
        pulseLog.delete();
        bus.i_start = 1'b1;
        bus.i_mode_linked = 1'b1;
        rstN = 1'b1;
        waitRunning(3000, ok);
        assertCount++;
        if (!ok || pulseLog.size() !== 3) begin
            failCount++;
            $display("[TB] FAIL restart_after_reset: got running=%b pulses=%0d, expected 1 and 3", ok, pulseLog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                assertCount++;
                if (pulseLog[i] !== expSeq[i]) begin
                    failCount++;
                    $display("[TB] FAIL restart_seq[%0d]: got %0d, expected %0d", i, pulseLog[i], expSeq[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        bit ok;
        pulseLog.delete();
        bus.i_start = 1'b0;
        waitLogSize(1, 100, ok);
        tick(400);
        assertCount++;
        if (!ok || pulseLog.size() !== 1 || pulseLog[0] !== 1) begin
            failCount++;
            $display("[TB] FAIL stop_pulses: got %0d pulses, expected exactly one soft_reset", pulseLog.size());
        end
        assertCount++;
        if (bus.o_running !== 1'b0 || bus.o_fault !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stop_idle: got running=%b fault=%b, expected 0 0", bus.o_running, bus.o_fault);
        end
    endtask

    task automatic test_ack_timeout();
        bit ok;
        pulseLog.delete();
        skipInit = 1'b1;
        bus.i_start = 1'b1;
        bus.i_mode_linked = 1'b1;
        waitFault(1000, ok);
        assertCount++;
        if (!ok || bus.o_fault_code !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL ack_timeout_code: got fault=%b code=%0d, expected 1 1", ok, bus.o_fault_code);
        end
        tick(100);
        assertCount++;
        if (pulseLog.size() !== 2 || bus.o_fault !== 1'b1 || bus.o_fault_code !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL ack_timeout_hold: got pulses=%0d fault=%b code=%0d, expected 2 1 1",
                     pulseLog.size(), bus.o_fault, bus.o_fault_code);
        end
        skipInit = 1'b0;
        bus.i_start = 1'b0;
        tick(300);
        assertCount++;
        if (pulseLog.size() !== 2 || bus.o_fault !== 1'b0 || bus.o_fault_code !== 2'd0 || bus.o_running !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ack_fault_exit: got pulses=%0d fault=%b code=%0d running=%b, expected 2 0 0 0",
                     pulseLog.size(), bus.o_fault, bus.o_fault_code, bus.o_running);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int n;
        pulseLog.delete();
        bus.i_start = 1'b1;
        waitRunning(3000, ok);
        n = 0;
        for (int i = 0; i < 5000 && !bus.o_fault; i++) begin
            tick(1);
            n++;
        end
        assertCount++;
        if (!ok || n !== 4000) begin
            failCount++;
            $display("[TB] FAIL watchdog_cycles: got %0d, expected 4000", n);
        end
        assertCount++;
        if (bus.o_fault_code !== 2'd3 || bus.o_running !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL watchdog_code: got code=%0d running=%b, expected 3 0", bus.o_fault_code, bus.o_running);
        end
        pulseLog.delete();
`ifdef ACL2_SEQ_AUTO_RECOVER_EN
        waitLogSize(1, 400, ok);
        assertCount++;
        if (!ok || pulseLog[0] !== 1 || bus.o_fault !== 1'b0 || bus.o_fault_code !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL recover_soft_reset: got pulse=%b fault=%b code=%0d, expected 1 0 0",
                     ok, bus.o_fault, bus.o_fault_code);
        end
        waitRunning(3000, ok);
        assertCount++;
        if (!ok || pulseLog.size() !== 3) begin
            failCount++;
            $display("[TB] FAIL recover_run: got running=%b pulses=%0d, expected 1 3", ok, pulseLog.size());
        end
`else
        tick(300);
        assertCount++;
        if (bus.o_fault !== 1'b1 || pulseLog.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL watchdog_hold: got fault=%b pulses=%0d, expected 1 0", bus.o_fault, pulseLog.size());
        end
        bus.i_start = 1'b0;
        tick(2);
        assertCount++;
        if (bus.o_fault !== 1'b0 || bus.o_fault_code !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL watchdog_exit: got fault=%b code=%0d, expected 0 0", bus.o_fault, bus.o_fault_code);
        end
`endif
        assertCount++;
        if (multiPulse !== 0) begin
            failCount++;
            $display("[TB] FAIL one_hot_pulses: got %0d overlapping cycles, expected 0", multiPulse);
        end
    endtask

    initial begin
        test_reset();
        test_power_up_linked();
        test_run_counting();
        test_preset_change();
        test_async_reset();
        test_stop();
        test_ack_timeout();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
